// File: rtl/ina_poll_scheduler.sv
// ina_poll_scheduler
//   Time-shares one INA219 I2C read engine across three current-sensor
//   channels. On every poll tick the scheduler sweeps channels 0, 1, 2 with
//   a req/ack/done handshake. It commits each result into per-channel
//   registers and tracks validity and consecutive-failure faults.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   enable           : polling enable
//   eng_req/addr/reg : request, target address and register pointer to engine
//   eng_ack          : engine accepted the request (1-cycle pulse)
//   eng_done/err/data: transaction finished, error flag, read word
//   eng_abort        : forces the engine back to idle after a timeout
//   val0..val2       : last good reading per channel
//   valid, fault     : per-channel good-streak and fault flags
//   sample_stb/ch    : commit strobe and channel of the committed result
//   overrun          : a poll tick arrived while a sweep was still running
module ina_poll_scheduler #(
  parameter int         POLL_PERIOD = 500000,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] ADDR0       = 8'h80,
  parameter logic [7:0] ADDR1       = 8'h82,
  parameter logic [7:0] ADDR2       = 8'h88,
  parameter logic [7:0] REG_PTR     = 8'h04,
  parameter int         MAX_FAIL    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        eng_req,
  output logic [7:0]  eng_addr,
  output logic [7:0]  eng_reg,
  input  logic        eng_ack,
  input  logic        eng_done,
  input  logic        eng_err,
  input  logic [15:0] eng_data,
  output logic        eng_abort,
  output logic [15:0] val0,
  output logic [15:0] val1,
  output logic [15:0] val2,
  output logic [2:0]  valid,
  output logic [2:0]  fault,
  output logic        sample_stb,
  output logic [1:0]  sample_ch,
  output logic        overrun
);

  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int OW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [OW-1:0] TMO_LAST   = OW'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_COMMIT    = 3'd4
  } state_t;

  state_t                state_r;
  logic [TW-1:0]         timer_r;
  logic [OW-1:0]         tmo_r;
  logic [1:0]            ch_r;
  logic [2:0][FW-1:0]    fail_r;
  logic [2:0][15:0]      val_r;
  logic [2:0]            valid_r;
  logic [2:0]            fault_r;
  logic                  eng_req_r;
  logic [7:0]            eng_addr_r;
  logic                  eng_abort_r;
  logic                  sample_stb_r;
  logic [1:0]            sample_ch_r;
  logic                  overrun_r;

  logic                  tick_s;
  logic                  timeout_s;
  logic                  sweeping_s;
  logic [FW-1:0]         fail_next_s;

  function automatic logic [7:0] ch_addr(input logic [1:0] c);
    case (c)
      2'd0:    ch_addr = ADDR0;
      2'd1:    ch_addr = ADDR1;
      2'd2:    ch_addr = ADDR2;
      default: ch_addr = ADDR0;
    endcase
  endfunction

  // Poll period timer: free-runs 0..POLL_PERIOD-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (!enable) begin
      timer_r <= '0;
    end else if (timer_r == TIMER_LAST) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Tick, timeout and saturating failure-count decode.
  always_comb begin
    tick_s      = 1'b0;
    timeout_s   = 1'b0;
    sweeping_s  = 1'b0;
    fail_next_s = fail_r[ch_r];
    if (enable && (timer_r == TIMER_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    // tmo_r holds the number of cycles elapsed since the ack cycle, so the
    // abort lands exactly TIMEOUT_CYC cycles after ack.
    if (tmo_r == TMO_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if ((state_r != S_IDLE) && (state_r != S_WAIT_TICK)) begin
      sweeping_s = 1'b1;
    end else begin
      sweeping_s = 1'b0;
    end
    if (fail_r[ch_r] == FAIL_MAX) begin
      fail_next_s = FAIL_MAX;
    end else begin
      fail_next_s = fail_r[ch_r] + FW'(1);
    end
  end

  // Sweep sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      ch_r         <= 2'd0;
      tmo_r        <= '0;
      fail_r       <= '0;
      val_r        <= '0;
      valid_r      <= 3'b000;
      fault_r      <= 3'b000;
      eng_req_r    <= 1'b0;
      eng_addr_r   <= 8'h00;
      eng_abort_r  <= 1'b0;
      sample_stb_r <= 1'b0;
      sample_ch_r  <= 2'd0;
      overrun_r    <= 1'b0;
    end else begin
      eng_abort_r  <= 1'b0;
      sample_stb_r <= 1'b0;
      overrun_r    <= tick_s && sweeping_s;
      case (state_r)
        S_IDLE: begin
          if (enable) begin
            state_r <= S_WAIT_TICK;
          end
        end
        S_WAIT_TICK: begin
          if (tick_s) begin
            ch_r       <= 2'd0;
            eng_req_r  <= 1'b1;
            eng_addr_r <= ch_addr(2'd0);
            state_r    <= S_REQ;
          end else if (!enable) begin
            state_r <= S_IDLE;
          end
        end
        S_REQ: begin
          // The request stays up until acked, regardless of enable.
          if (eng_ack) begin
            eng_req_r <= 1'b0;
            tmo_r     <= OW'(1);
            state_r   <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // Results are committed on this edge so they appear one cycle after
          // done; done beats a coincident timeout.
          if (eng_done || timeout_s) begin
            state_r      <= S_COMMIT;
            sample_stb_r <= 1'b1;
            sample_ch_r  <= ch_r;
            eng_abort_r  <= !eng_done;
            if (eng_done && !eng_err) begin
              val_r[ch_r]   <= eng_data;
              valid_r[ch_r] <= 1'b1;
              fail_r[ch_r]  <= '0;
              fault_r[ch_r] <= 1'b0;
            end else begin
              fail_r[ch_r] <= fail_next_s;
              if (fail_next_s == FAIL_MAX) begin
                fault_r[ch_r] <= 1'b1;
                valid_r[ch_r] <= 1'b0;
              end
            end
          end else begin
            tmo_r <= tmo_r + OW'(1);
          end
        end
        S_COMMIT: begin
          if (ch_r != 2'd2) begin
            ch_r       <= ch_r + 2'd1;
            eng_req_r  <= 1'b1;
            eng_addr_r <= ch_addr(ch_r + 2'd1);
            state_r    <= S_REQ;
          end else begin
            ch_r    <= 2'd0;
            state_r <= enable ? S_WAIT_TICK : S_IDLE;
          end
        end
        default: begin
          eng_req_r <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign eng_req    = eng_req_r;
  assign eng_addr   = eng_addr_r;
  assign eng_reg    = REG_PTR;
  assign eng_abort  = eng_abort_r;
  assign val0       = val_r[0];
  assign val1       = val_r[1];
  assign val2       = val_r[2];
  assign valid      = valid_r;
  assign fault      = fault_r;
  assign sample_stb = sample_stb_r;
  assign sample_ch  = sample_ch_r;
  assign overrun    = overrun_r;

endmodule

// File: doc/ina_poll_scheduler.md
Name: ina_poll_scheduler

Overview:
- Sequences one shared INA219 I2C read engine across three current-sensor channels, replacing three free-running per-bus masters.
- Each poll tick sweeps channels 0, 1, 2 in order with a request/ack/done handshake, then stores the results.
- Tracks per-channel validity and communication faults, and feeds the relay-protection and LCD logic.

Parameters:
- POLL_PERIOD, 500000: clk cycles between sweep starts (10 ms at 50 MHz).
- TIMEOUT_CYC, 100000: max cycles from ack to done before the transaction is declared failed.
- ADDR0, 8'h80: write-form I2C address for channel 0.
- ADDR1, 8'h82: write-form I2C address for channel 1.
- ADDR2, 8'h88: write-form I2C address for channel 2.
- REG_PTR, 8'h04: INA219 register pointer read on every transaction (current register).
- MAX_FAIL, 3: consecutive failures before fault is raised.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- enable, in, 1: polling enable.
- eng_req, out, 1: transaction request to the read engine.
- eng_addr, out, 8: target address; valid while eng_req=1.
- eng_reg, out, 8: register pointer; always REG_PTR.
- eng_ack, in, 1: 1-cycle pulse; engine accepted the request.
- eng_done, in, 1: 1-cycle pulse; transaction finished.
- eng_err, in, 1: qualifies eng_done; 1 = NACK or bus error.
- eng_data, in, 16: read word; valid when eng_done=1.
- eng_abort, out, 1: 1-cycle pulse; engine must return to idle.
- val0, val1, val2, out, 16 each: last good reading per channel.
- valid, out, 3: bit n = val{n} holds a reading from the current good streak.
- fault, out, 3: bit n = channel n reached MAX_FAIL consecutive failures.
- sample_stb, out, 1: 1-cycle pulse when a channel result is committed (good or failed).
- sample_ch, out, 2: channel of the committed result; valid with sample_stb.
- overrun, out, 1: 1-cycle pulse; a poll tick arrived while a sweep was in progress.

Behaviour:
- Reset (async assert, sync release): state IDLE, ch=0, all outputs 0, val*=0, fail counters 0, period timer 0.
- Period timer:
  - Counts 0..POLL_PERIOD-1 and wraps while enable=1; tick is asserted in the wrap cycle.
  - Held at 0 while enable=0.
- States:
  - IDLE: enable=1 -> WAIT_TICK.
  - WAIT_TICK: tick -> REQ with ch=0. enable=0 -> IDLE.
  - REQ: eng_req=1 and eng_addr=ADDR[ch]. On eng_ack, eng_req drops the next cycle, the timeout counter clears, and the FSM goes to WAIT_DONE. A request is never withdrawn once raised, even if enable falls.
  - WAIT_DONE: the timeout counter increments each cycle. eng_done -> COMMIT. Counter reaching TIMEOUT_CYC -> eng_abort pulse for 1 cycle, the result is treated as an error, then COMMIT.
  - COMMIT (1 cycle): sample_stb=1 and sample_ch=ch.
    - Success: val[ch]<=eng_data, valid[ch]<=1, fail[ch]<=0, fault[ch]<=0.
    - Error: fail[ch] increments, saturating at MAX_FAIL; when it reaches MAX_FAIL, fault[ch]<=1 and valid[ch]<=0. val[ch] holds its last good value.
    - Then ch<2 -> ch+1 and REQ; ch==2 -> ch=0 and WAIT_TICK if enable=1, else IDLE.
- Latency: val, valid and sample_stb update exactly 1 cycle after eng_done.
- Handshake edge cases:
  - eng_done and timeout in the same cycle: done wins and no abort is issued.
  - eng_done/eng_ack received outside WAIT_DONE/REQ: ignored.
  - eng_ack in the same cycle eng_req first rises: accepted.
- Overrun: a tick in any state other than WAIT_TICK or IDLE pulses overrun; the sweep continues and the tick is dropped. No queueing.
- enable falling mid-sweep: the current transaction and the remaining channels of the sweep complete, then the FSM goes to IDLE. Outputs hold their values.
- Reset mid-transaction: immediate return to reset values. The engine is reset by the same rst_n.

Test Plan (POLL_PERIOD=100, TIMEOUT_CYC=20, MAX_FAIL=3):
1. enable=1; engine model acks after 2 cycles and returns done with data 16'h0100/0200/0300 for ch0/1/2 -> eng_addr sequence 80, 82, 88; val0..2=0100/0200/0300; valid=3'b111; three sample_stb pulses with sample_ch 0, 1, 2; next sweep starts 100 cycles after the first.
2. ch1 returns eng_err for 3 consecutive sweeps -> fault=3'b010 after the third commit, valid[1]=0, val1 holds 0200; a following good read 0250 -> fault[1]=0, valid[1]=1, val1=0250.
3. ch2 engine never sends done -> eng_abort pulses exactly 20 cycles after ack; error committed; next sweep proceeds normally.
4. Engine slowed so one sweep takes >100 cycles -> overrun pulses once per missed tick; no duplicate or skipped channel within a sweep.
5. enable dropped while waiting for ch0 done -> ch0, ch1 and ch2 complete, FSM goes to IDLE, no further eng_req; re-enable -> first sweep starts 100 cycles later.
6. rst_n asserted during WAIT_DONE -> eng_req=0, val*=0, valid=0, fault=0 in the same cycle, asynchronously.
